uart_fifo_ctl: RTL and testbench
================================

# uart_fifo_ctl

- Parametrised UART transceiver with independent TX and RX FIFOs, RTS/CTS hardware flow control, framing/overflow reporting and internal loopback.
- Replaces the fixed 8-bit, unbuffered UART controller between the board pins (`rx`, `tx`, `cts`, `rts`) and the I/O-side logic (switches/LEDs or any other byte producer/consumer).
- The I/O side talks to it over two valid/ready streams.

## Interface
- `CLK_DIV`, 868, clock cycles per bit, ≥ 4 (100 MHz / 115200).
- `DATA_W`, 8, data bits per frame, 5..8; no parity, one stop bit.
- `FIFO_DEPTH`, 16, entries per FIFO, power of two, ≥ 4.
- `RTS_MARGIN`, 4, free RX slots below which `rts` deasserts, 1..FIFO_DEPTH-1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock; asynchronous, active-low.
- `rx`  in  1  serial input, asynchronous to `clk`.
- `cts`  in  1  clear-to-send, active-low (0 = peer may receive).
- `tx`  out  1  serial output, idle high.
- `rts`  out  1  request-to-send, active-low (0 = we can receive).
- `tx_data`  in  DATA_W  byte to send.
- `tx_valid`  in  1  `tx_data` valid.
- `tx_ready`  out  1  TX FIFO not full.
- `rx_data`  out  DATA_W  head of RX FIFO (show-ahead).
- `rx_valid`  out  1  RX FIFO not empty.
- `rx_ready`  in  1  pop RX head.
- `loopback`  in  1  1 = internal `tx`→`rx` path.
- `rx_err`  out  1  one-cycle pulse on framing error.
- `rx_ovf`  out  1  sticky overflow flag, cleared only by reset.
- `tx_level`, `rx_level`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- Transfers occur when valid & ready are both high at a rising edge. Data is LSB first.
- **TX FSM** (IDLE, START, DATA, STOP):
  - IDLE→START when the TX FIFO is non-empty and the synchronised `cts`=0. The head is popped into the shift register on this transition.
  - Each state lasts CLK_DIV cycles; DATA lasts DATA_W bit periods.
  - STOP→IDLE at the end of the stop bit; back-to-back frames take no extra idle cycles.
  - `cts` going high mid-frame does not abort the frame; it only blocks the next START.
- **RX FSM** (IDLE, START, DATA, STOP):
  - The line passes a 2-flop synchroniser, and is then muxed with the internal tx when `loopback`=1.
  - A falling edge in IDLE enters START. START re-checks the line at CLK_DIV/2; if it is high, the edge was a glitch and the FSM returns to IDLE.
  - DATA samples every CLK_DIV cycles from that midpoint.
  - STOP samples the stop bit. If it is 1, the byte is pushed. If it is 0, the byte is dropped, `rx_err` pulses, and the FSM returns to IDLE only after the line is seen high.
- **Overflow**: a byte that completes while the RX FIFO is full is dropped and `rx_ovf` sets. If `rx_ready` pops in the same cycle, the push succeeds.
- **`rts`**: registered; 1 when RX free slots < RTS_MARGIN, else 0.
- **Loopback**: the `tx` pin is held at 1 and `rx` is ignored.
  - Changing `loopback` mid-frame corrupts that frame only.
  - Flagging the corrupted frame as an error is allowed; hanging is not.
- **FIFOs**: `*_level` is exact. Pointers wrap modulo FIFO_DEPTH, with one extra bit distinguishing full from empty.

## Timing
- **Reset values**: `tx`=1, `rts`=1, `tx_ready`=0, `rx_valid`=0, `rx_data`=0, `rx_err`=0, `rx_ovf`=0, levels 0.
  - `tx_ready` rises and `rts` falls on the first edge after `rst` deasserts.
- **Reset mid-frame**: `tx` returns high asynchronously, both FIFOs empty, and FSMs return to IDLE.
- **TX latency**: with the FIFO empty and `cts`=0, `tx` falls 2 cycles after the accepting edge. The frame is (DATA_W+2)·CLK_DIV cycles.
- **RX latency**: `rx_valid` rises 2 cycles after the stop-bit mid-sample. This is ~(DATA_W+1.5)·CLK_DIV + 4 cycles after the pin's falling edge, including the synchroniser.
- **`cts` sampling**: synchronised with 2 flops, so it takes effect 2 cycles late.

## Structure
- Package `uart_pkg`:
  - TX and RX state enums.
  - Default CLK_DIV.
  - Level-width function.
- Sub-module `sync_fifo` (params WIDTH, DEPTH): show-ahead, with full/empty/level outputs. Instantiated twice.
- TX FSM, RX FSM, synchronisers and `rts` logic are in the top.

## Test plan
- **TX frame**: CLK_DIV=16, DATA_W=8, push 0xA5 with `cts`=0. Required: `tx` low 2 cycles later, bits 1,0,1,0,0,1,0,1, each 16 cycles, then stop high. Total 160 cycles.
- **RX frame**: drive frame 0x3C at CLK_DIV=16. Required: `rx_valid`=1 with `rx_data`=0x3C, `rx_level`=1, `rx_err`=0.
- **Framing error**: drive 0x55 with stop bit 0. Required: one `rx_err` pulse, no push; the next valid frame 0x12 is received.
- **Flow control**:
  - FIFO_DEPTH=8, RTS_MARGIN=2: receive 7 bytes without popping. Required: `rts`=1 after the 7th byte.
  - A 9th byte sets `rx_ovf`.
  - Hold `cts`=1 with 3 bytes queued: no start bit; release → 3 back-to-back frames.
- **Loopback**: `loopback`=1, push 0x00, 0xFF, 0x81. Required: same bytes in order on rx, and the `tx` pin constantly 1.
- **Reset mid-frame**: assert `rst` during DATA. Required: `tx`=1 immediately and levels 0. After release, a fresh push transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART controller.
package uart_pkg;

    // 100 MHz system clock / 115200 baud
    localparam int unsigned CLK_DIV_DEFAULT = 868;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Width of an occupancy count that must represent 0..depth inclusive
    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_ctl_if.sv
// Byte streams between the UART controller and the I/O-side logic.
interface uart_fifo_ctl_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    // I/O-side producer/consumer
    modport master (output tx_data, tx_valid, rx_ready,
                    input  tx_ready, rx_data, rx_valid);
    // UART controller
    modport slave  (input  tx_data, tx_valid, rx_ready,
                    output tx_ready, rx_data, rx_valid);
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_push,
    input  logic [WIDTH-1:0]            i_data,
    input  logic                        i_pop,
    output logic [WIDTH-1:0]            o_data,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [level_w(DEPTH)-1:0]   o_level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_level   = r_wptr - r_rptr;
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    // Storage write, no reset needed since reads are gated by empty
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

    // Read/write pointer advance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end
endmodule

// File: rtl/uart_fifo_ctl.sv
// Buffered UART with RTS/CTS flow control, error reporting and loopback.
module uart_fifo_ctl
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = CLK_DIV_DEFAULT,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned RTS_MARGIN = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rx,
    input  logic                             cts,
    input  logic                             loopback,
    output logic                             tx,
    output logic                             rts,
    output logic                             rx_err,
    output logic                             rx_ovf,
    output logic [level_w(FIFO_DEPTH)-1:0]   tx_level,
    output logic [level_w(FIFO_DEPTH)-1:0]   rx_level,
    uart_fifo_ctl_if.slave                   bus
);
    localparam int unsigned LW = level_w(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam int unsigned BW = $clog2(DATA_W + 1);

    logic r_en, r_cts_s1, r_cts_s2, r_rx_s1, r_rx_s2, r_tx, r_rts, r_ovf;

    tx_state_t         r_tx_state;
    logic [CW-1:0]     r_tx_cnt;
    logic [BW-1:0]     r_tx_bit;
    logic [DATA_W-1:0] r_tx_shift;
    logic [DATA_W-1:0] w_tx_head;
    logic              w_tx_full, w_tx_empty, w_tx_push, w_tx_pop, w_tx_tick;

    rx_state_t         r_rx_state;
    logic [CW-1:0]     r_rx_cnt;
    logic [BW-1:0]     r_rx_bit;
    logic [DATA_W-1:0] r_rx_shift;
    logic              r_rx_brk, r_rx_push, r_rx_err;
    logic              w_rx_full, w_rx_empty, w_rx_pop, w_rx_line, w_rx_tick;

    assign bus.tx_ready = r_en & ~w_tx_full;
    assign w_tx_push    = bus.tx_valid & bus.tx_ready;
    assign w_tx_tick    = (r_tx_cnt == CW'(CLK_DIV - 1));
    // Pop on leaving IDLE, or straight out of STOP so back-to-back frames have no gap
    assign w_tx_pop     = ~w_tx_empty & ~r_cts_s2 &
                          ((r_tx_state == TX_IDLE) || ((r_tx_state == TX_STOP) && w_tx_tick));
    assign tx           = r_tx | loopback;

    assign bus.rx_valid = ~w_rx_empty;
    assign w_rx_pop     = bus.rx_ready & ~w_rx_empty;
    assign w_rx_line    = loopback ? r_tx : r_rx_s2;
    assign w_rx_tick    = (r_rx_cnt == CW'(CLK_DIV - 1));
    assign rx_err       = r_rx_err;
    assign rx_ovf       = r_ovf;
    assign rts          = r_rts;

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .i_push(w_tx_push), .i_data(bus.tx_data), .i_pop(w_tx_pop),
        .o_data(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty), .o_level(tx_level)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .i_push(r_rx_push), .i_data(r_rx_shift), .i_pop(w_rx_pop),
        .o_data(bus.rx_data), .o_full(w_rx_full), .o_empty(w_rx_empty), .o_level(rx_level)
    );

    // Input synchronisers (idle-high lines) and post-reset ready enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {r_cts_s1, r_cts_s2, r_rx_s1, r_rx_s2} <= '1;
            r_en <= 1'b0;
        end else begin
            r_cts_s1 <= cts;
            r_cts_s2 <= r_cts_s1;
            r_rx_s1  <= rx;
            r_rx_s2  <= r_rx_s1;
            r_en     <= 1'b1;
        end
    end

    // TX sequencer: start, DATA_W bits LSB first, stop; each CLK_DIV cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    r_tx_cnt <= '0;
                    if (w_tx_pop) begin
                        r_tx_state <= TX_START;
                        r_tx_shift <= w_tx_head;
                    end
                end
                TX_START: begin
                    if (w_tx_tick) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx_state <= TX_DATA;
                    end else r_tx_cnt <= r_tx_cnt + 1'b1;
                end
                TX_DATA: begin
                    if (w_tx_tick) begin
                        r_tx_cnt   <= '0;
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_bit   <= r_tx_bit + 1'b1;
                        if (r_tx_bit == BW'(DATA_W - 1)) r_tx_state <= TX_STOP;
                    end else r_tx_cnt <= r_tx_cnt + 1'b1;
                end
                TX_STOP: begin
                    if (w_tx_tick) begin
                        r_tx_cnt <= '0;
                        if (w_tx_pop) begin
                            r_tx_state <= TX_START;
                            r_tx_shift <= w_tx_head;
                        end else r_tx_state <= TX_IDLE;
                    end else r_tx_cnt <= r_tx_cnt + 1'b1;
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    // Registered serial output, one cycle behind the sequencer state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_tx <= 1'b1;
        else      r_tx <= (r_tx_state == TX_START) ? 1'b0 :
                          (r_tx_state == TX_DATA)  ? r_tx_shift[0] : 1'b1;
    end

    // RX sequencer: midpoint-qualified start, mid-bit sampling, stop check
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_brk   <= 1'b0;
            r_rx_push  <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            r_rx_push <= 1'b0;
            r_rx_err  <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt <= '0;
                    r_rx_brk <= 1'b0;
                    if (!w_rx_line) r_rx_state <= RX_START;
                end
                RX_START: begin
                    if (r_rx_cnt == CW'(CLK_DIV / 2 - 1)) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= w_rx_line ? RX_IDLE : RX_DATA;
                    end else r_rx_cnt <= r_rx_cnt + 1'b1;
                end
                RX_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {w_rx_line, r_rx_shift[DATA_W-1:1]};
                        r_rx_bit   <= r_rx_bit + 1'b1;
                        if (r_rx_bit == BW'(DATA_W - 1)) r_rx_state <= RX_STOP;
                    end else r_rx_cnt <= r_rx_cnt + 1'b1;
                end
                RX_STOP: begin
                    // After a bad stop bit, hold here until the line idles high
                    if (r_rx_brk) begin
                        if (w_rx_line) r_rx_state <= RX_IDLE;
                    end else if (w_rx_tick) begin
                        r_rx_cnt <= '0;
                        if (w_rx_line) begin
                            r_rx_push  <= 1'b1;
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_err <= 1'b1;
                            r_rx_brk <= 1'b1;
                        end
                    end else r_rx_cnt <= r_rx_cnt + 1'b1;
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // Sticky overflow and registered RTS from RX free space
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
            r_rts <= 1'b1;
        end else begin
            r_ovf <= r_ovf | (r_rx_push & w_rx_full & ~w_rx_pop);
            r_rts <= (LW'(FIFO_DEPTH) - rx_level) < LW'(RTS_MARGIN);
        end
    end
endmodule

// File: tb/tb_uart_fifo_ctl.sv
// Self-checking bench for uart_fifo_ctl: directed steps plus random bytes vs a queue model.
module tb_uart_fifo_ctl;
    localparam int unsigned CLK_DIV = 16;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned MARGIN  = 2;
    localparam int unsigned LW      = 4;

    logic          clk = 1'b0;
    logic          rst, rx_pin, cts, loopback;
    logic          tx, rts, rx_err, rx_ovf;
    logic [LW-1:0] tx_level, rx_level;

    int n_checks = 0;
    int n_pass   = 0;
    int err_seen = 0;

    uart_fifo_ctl_if #(.DATA_W(8)) bus ();

    uart_fifo_ctl #(.CLK_DIV(CLK_DIV), .DATA_W(8), .FIFO_DEPTH(DEPTH), .RTS_MARGIN(MARGIN)) dut (
        .clk(clk), .rst(rst), .rx(rx_pin), .cts(cts), .loopback(loopback),
        .tx(tx), .rts(rts), .rx_err(rx_err), .rx_ovf(rx_ovf),
        .tx_level(tx_level), .rx_level(rx_level), .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rx_err === 1'b1) err_seen <= err_seen + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic push_tx(input logic [7:0] b);
        int k = 0;
        while (bus.tx_ready !== 1'b1 && k < 200) begin tick(1); k++; end
        chk("tx_ready_wait", {31'd0, bus.tx_ready}, 32'd1);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        tick(1);
        bus.tx_valid = 1'b0;
    endtask

    task automatic pop_rx(output logic [7:0] b);
        b = bus.rx_data;
        bus.rx_ready = 1'b1;
        tick(1);
        bus.rx_ready = 1'b0;
    endtask

    // Drive one frame on the rx pin, LSB first
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        rx_pin = 1'b0;
        tick(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            tick(CLK_DIV);
        end
        rx_pin = stop_bit;
        tick(CLK_DIV);
        rx_pin = 1'b1;
        tick(4);
    endtask

    // Wait for a start bit on tx, then decode the frame at bit centres
    task automatic read_tx_frame(output logic [7:0] b, output int waited);
        waited = 0;
        b = '0;
        while (tx !== 1'b0 && waited < 400) begin tick(1); waited++; end
        chk("tx_start_seen", {31'd0, tx}, 32'd0);
        tick(CLK_DIV / 2);
        chk("tx_start_mid", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick(CLK_DIV);
            b[i] = tx;
        end
        tick(CLK_DIV);
        chk("tx_stop_mid", {31'd0, tx}, 32'd1);
    endtask

    initial begin
        logic [7:0] b, exp_b;
        logic [7:0] q[$];
        logic       ovf_m;
        int         waited, base, lows, k;

        rst = 1'b0; rx_pin = 1'b1; cts = 1'b0; loopback = 1'b0;
        bus.tx_data = '0; bus.tx_valid = 1'b0; bus.rx_ready = 1'b0;

        // Reset values
        tick(3);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_rts", {31'd0, rts}, 32'd1);
        chk("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd0);
        chk("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
        chk("rst_rx_err", {31'd0, rx_err}, 32'd0);
        chk("rst_rx_ovf", {31'd0, rx_ovf}, 32'd0);
        chk("rst_tx_level", {28'd0, tx_level}, 32'd0);
        chk("rst_rx_level", {28'd0, rx_level}, 32'd0);
        rst = 1'b1;
        tick(1);
        chk("post_rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        chk("post_rst_rts", {31'd0, rts}, 32'd0);
        tick(3);

        // TX frame 0xA5: latency 2 cycles, LSB first, 16 cycles per bit
        bus.tx_data = 8'hA5; bus.tx_valid = 1'b1;
        tick(1);
        bus.tx_valid = 1'b0;
        chk("a5_level_after_push", {28'd0, tx_level}, 32'd1);
        chk("a5_tx_idle_e0", {31'd0, tx}, 32'd1);
        tick(1);
        chk("a5_tx_idle_e1", {31'd0, tx}, 32'd1);
        tick(1);
        chk("a5_tx_low_e2", {31'd0, tx}, 32'd0);
        read_tx_frame(b, waited);
        chk("a5_start_latency", waited, 32'd0);
        chk("a5_data", {24'd0, b}, 32'hA5);
        tick(CLK_DIV / 2);
        chk("a5_idle_after", {31'd0, tx}, 32'd1);
        chk("a5_tx_level", {28'd0, tx_level}, 32'd0);

        // RX frame 0x3C
        base = err_seen;
        send_rx(8'h3C, 1'b1);
        chk("rx3c_valid", {31'd0, bus.rx_valid}, 32'd1);
        chk("rx3c_data", {24'd0, bus.rx_data}, 32'h3C);
        chk("rx3c_level", {28'd0, rx_level}, 32'd1);
        chk("rx3c_no_err", err_seen - base, 32'd0);
        pop_rx(b);
        chk("rx3c_level_after_pop", {28'd0, rx_level}, 32'd0);

        // Framing error on 0x55, then a clean 0x12
        base = err_seen;
        send_rx(8'h55, 1'b0);
        tick(4);
        chk("ferr_pulse_count", err_seen - base, 32'd1);
        chk("ferr_no_push", {28'd0, rx_level}, 32'd0);
        send_rx(8'h12, 1'b1);
        chk("ferr_next_data", {24'd0, bus.rx_data}, 32'h12);
        chk("ferr_next_valid", {31'd0, bus.rx_valid}, 32'd1);
        pop_rx(b);

        // Flow control and overflow with random bytes against a queue model
        q.delete();
        ovf_m = 1'b0;
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            send_rx(b, 1'b1);
            if (q.size() < DEPTH) q.push_back(b);
            else ovf_m = 1'b1;
            chk("flow_rts", {31'd0, rts}, ((DEPTH - q.size()) < MARGIN) ? 32'd1 : 32'd0);
            chk("flow_ovf", {31'd0, rx_ovf}, {31'd0, ovf_m});
            chk("flow_level", {28'd0, rx_level}, q.size());
        end
        while (q.size() > 0) begin
            exp_b = q.pop_front();
            pop_rx(b);
            chk("flow_data", {24'd0, b}, {24'd0, exp_b});
        end
        tick(2);
        chk("flow_rts_released", {31'd0, rts}, 32'd0);
        chk("flow_ovf_sticky", {31'd0, rx_ovf}, 32'd1);

        // CTS hold with 3 bytes queued, then back-to-back release
        cts = 1'b1;
        tick(3);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            push_tx(b);
        end
        lows = 0;
        repeat (40) begin
            tick(1);
            if (tx !== 1'b1) lows++;
        end
        chk("cts_hold_no_start", lows, 32'd0);
        chk("cts_hold_level", {28'd0, tx_level}, 32'd3);
        cts = 1'b0;
        for (int i = 0; i < 3; i++) begin
            read_tx_frame(b, waited);
            exp_b = q.pop_front();
            chk("cts_frame_data", {24'd0, b}, {24'd0, exp_b});
            if (i > 0) chk("cts_back_to_back_gap", waited, CLK_DIV / 2);
        end

        // Loopback: bytes return in order, pin stays high
        tick(CLK_DIV);
        loopback = 1'b1;
        tick(2);
        lows = 0;
        foreach (q[i]) q.delete(i);
        q.push_back(8'h00); q.push_back(8'hFF); q.push_back(8'h81);
        base = err_seen;
        foreach (q[i]) begin
            push_tx(q[i]);
            if (tx !== 1'b1) lows++;
        end
        k = 0;
        while (rx_level < 3 && k < 800) begin
            tick(1);
            k++;
            if (tx !== 1'b1) lows++;
        end
        chk("lb_level", {28'd0, rx_level}, 32'd3);
        chk("lb_tx_pin_high", lows, 32'd0);
        chk("lb_no_err", err_seen - base, 32'd0);
        while (q.size() > 0) begin
            exp_b = q.pop_front();
            pop_rx(b);
            chk("lb_data", {24'd0, b}, {24'd0, exp_b});
        end
        loopback = 1'b0;
        tick(4);

        // Reset during DATA, then a fresh frame
        push_tx(8'($urandom));
        push_tx(8'($urandom));
        k = 0;
        while (tx !== 1'b0 && k < 100) begin tick(1); k++; end
        tick(40);
        chk("mid_tx_level", {28'd0, tx_level}, 32'd1);
        #3 rst = 1'b0;
        #1;
        chk("mid_rst_tx_high", {31'd0, tx}, 32'd1);
        chk("mid_rst_tx_level", {28'd0, tx_level}, 32'd0);
        chk("mid_rst_rx_level", {28'd0, rx_level}, 32'd0);
        chk("mid_rst_ovf_clear", {31'd0, rx_ovf}, 32'd0);
        tick(2);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_ready", {31'd0, bus.tx_ready}, 32'd1);
        exp_b = 8'($urandom);
        push_tx(exp_b);
        read_tx_frame(b, waited);
        chk("mid_rst_fresh_data", {24'd0, b}, {24'd0, exp_b});
        tick(CLK_DIV);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
